// File: rtl/systolic_input_feeder.sv
// rtl/systolic_input_feeder.sv - feeds one operand tile into the skew array, then flushes it
module systolic_input_feeder #(
  parameter int ROWS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int K_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [K_WIDTH-1:0]         k_len,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] s_data,
  output logic [ROWS*DATA_WIDTH-1:0] out_data,
  output logic                       out_enable,
  output logic                       busy,
  output logic                       done
);

  localparam int FW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'((ROWS > 1) ? ROWS - 2 : 0);
  localparam logic [K_WIDTH-1:0] K_ONE = K_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t             state, state_nx;
  logic [K_WIDTH-1:0] k_lat;
  logic [K_WIDTH-1:0] beat_cnt;
  logic [FW-1:0]      flush_cnt;
  logic               beat;
  logic               last_beat;
  logic               flush_last;
  logic               accept;

  assign s_ready    = (state == STREAM);
  assign busy       = (state != IDLE) || done;
  assign beat       = s_valid && s_ready;
  // Compare against K-1 so the counter never has to hold a value past K.
  assign last_beat  = beat && (beat_cnt == (k_lat - K_ONE));
  assign flush_last = (flush_cnt == FLUSH_LAST);
  assign accept     = (state == IDLE) && start && !busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (k_len != '0) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (last_beat) begin
          state_nx = (ROWS == 1) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (flush_last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (accept) begin
        k_lat     <= k_len;
        beat_cnt  <= '0;
        flush_cnt <= '0;
      end
      if (beat) begin
        beat_cnt <= beat_cnt + K_ONE;
      end
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + FW'(1);
      end
    end
  end

  // Outside enable cycles the data register holds; consumers qualify with out_enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_enable <= 1'b0;
      done       <= 1'b0;
    end else begin
      out_enable <= beat || (state == FLUSH);
      done       <= (state == DONE);
      if (beat) begin
        out_data <= s_data;
      end else if (state == FLUSH) begin
        out_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// tb/tb_systolic_input_feeder.sv - directed table-driven bench for systolic_input_feeder
module tb_systolic_input_feeder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  k_len;
  logic        s_valid;
  logic        s_ready;
  logic [63:0] s_data;
  logic [63:0] out_data;
  logic        out_enable;
  logic        busy;
  logic        done;

  int checks;
  int passes;

  systolic_input_feeder #(.ROWS(4), .DATA_WIDTH(16), .K_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .out_data(out_data), .out_enable(out_enable), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [63:0] stall;
    bit          reassert;
    int          exp_en;
    int          exp_ready;
    int          exp_done;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [63:0] vec(input int j);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      r[16*l +: 16] = 16'(j * 16 + l + 1) ^ 16'(l << 12);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Cycle c: inputs driven at the negedge inside c, outputs sampled at that negedge first.
  task automatic run_tile(input vec_t v, input int id);
    int en_n, rdy_n, busy_n, done_n, done_c, last_en, beats;
    logic [63:0] expd;
    string tag;
    en_n = 0; rdy_n = 0; busy_n = 0; done_n = 0; done_c = -1; last_en = -1; beats = 0;
    tag = $sformatf("t%0d", id);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c > 0) begin
        if (out_enable) begin
          expd = (en_n < v.k) ? vec(en_n) : 64'h0;
          chk({tag, "_data"}, out_data, expd);
          en_n++;
          last_en = c;
        end
        if (busy) busy_n++;
        if (done) begin
          done_n++;
          if (done_c < 0) done_c = c;
        end
      end
      if (done_c >= 0 && c >= done_c + 3) break;
      start = (c == 0) || (v.reassert && (c == 2 || c == done_c));
      if (c == 0) k_len = 8'(v.k);
      else if (v.reassert && c == 2) k_len = 8'd7;
      else if (v.reassert && c == done_c) k_len = 8'd5;
      s_valid = (c < 64) ? !v.stall[c] : 1'b1;
      s_data = vec(beats);
      #1;
      if (s_ready) rdy_n++;
      if (s_valid && s_ready) beats++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk({tag, "_en_cnt"}, 64'(en_n), 64'(v.exp_en));
    chk({tag, "_ready_cnt"}, 64'(rdy_n), 64'(v.exp_ready));
    chk({tag, "_beats"}, 64'(beats), 64'(v.k));
    chk({tag, "_done_cnt"}, 64'(done_n), 64'd1);
    chk({tag, "_done_cycle"}, 64'(done_c), 64'(v.exp_done));
    chk({tag, "_busy_cnt"}, 64'(busy_n), 64'(v.exp_done));
    if (v.k > 0) chk({tag, "_done_after_en"}, 64'(done_c), 64'(last_en + 1));
  endtask

  initial begin
    int done_seen;
    checks = 0;
    passes = 0;
    rst_n = 1'b0; start = 1'b0; k_len = '0; s_valid = 1'b0; s_data = '0;

    tbl[0] = '{k: 3,   stall: 64'h0, reassert: 1'b0, exp_en: 6,   exp_ready: 3,   exp_done: 8};
    tbl[1] = '{k: 3,   stall: 64'hC, reassert: 1'b0, exp_en: 6,   exp_ready: 5,   exp_done: 10};
    tbl[2] = '{k: 0,   stall: 64'h0, reassert: 1'b0, exp_en: 0,   exp_ready: 0,   exp_done: 2};
    tbl[3] = '{k: 3,   stall: 64'h0, reassert: 1'b1, exp_en: 6,   exp_ready: 3,   exp_done: 8};
    tbl[4] = '{k: 1,   stall: 64'h0, reassert: 1'b0, exp_en: 4,   exp_ready: 1,   exp_done: 6};
    tbl[5] = '{k: 2,   stall: 64'h2, reassert: 1'b0, exp_en: 5,   exp_ready: 3,   exp_done: 8};
    tbl[6] = '{k: 255, stall: 64'h0, reassert: 1'b0, exp_en: 258, exp_ready: 255, exp_done: 260};

    repeat (2) @(negedge clk);
    chk("rst_out_enable", 64'(out_enable), 64'd0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    rst_n = 1'b1;

    // Reset while FLUSH holds the last data vector on the output.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("mid_pre_enable", 64'(out_enable), 64'd1);
        chk("mid_pre_data", out_data, vec(2));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_enable", 64'(out_enable), 64'd0);
        chk("mid_rst_data", out_data, 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ready", 64'(s_ready), 64'd0);
      end else begin
        start = (c == 0);
        k_len = 8'd3;
        s_valid = 1'b1;
        s_data = vec(c - 1);
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || out_enable) done_seen++;
      if (c == 1) rst_n = 1'b1;
    end
    chk("mid_rst_no_done", 64'(done_seen), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_tile(tbl[i], i);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
